// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, write ports, scoreboard control and debug views.
// The master side is issue/writeback logic; the slave side is the register file.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0]  rd_data;
    logic [NUM_READ-1:0]             rd_busy;
    logic [NUM_WRITE-1:0]            wr_en;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
    logic                            rsv_en;
    logic [ADDR_WIDTH-1:0]           rsv_addr;
    logic                            flush;
    logic [NUM_REGS-1:0]             busy_out;
    logic [NUM_REGS*DATA_WIDTH-1:0]  registers_out;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, busy_out, registers_out
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, busy_out, registers_out
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy scoreboard; x0 reads zero and is never busy.
// Optional macro REG_FILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file_mp #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    NUM_READ   = 2,
    parameter int                    NUM_WRITE  = 1,
    parameter int                    SP_INDEX   = 2,
    parameter logic [DATA_WIDTH-1:0] INITIAL_SP = 32'h03FF_FFFC
) (
    input  logic          clock,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]            busy_q;
    logic [NUM_REGS-1:0]            busy_d;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_READ-1:0]            rd_busy_c;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;
    logic [ADDR_WIDTH-1:0]          ra;
`ifdef REG_FILE_BYPASS_EN
    logic                           fwd;
`endif

    // Ascending port order lets the highest-index writer win an address conflict.
    always_comb begin : next_state
        regs_d = regs_q;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0))
                regs_d[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
        regs_d[0] = '0;

        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0))
                    busy_d[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
            // A new reservation supersedes a writeback to the same register.
            if (bus.rsv_en && (bus.rsv_addr != '0))
                busy_d[bus.rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_q[r] <= (r == SP_INDEX) ? INITIAL_SP : '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin : read_ports
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
`ifdef REG_FILE_BYPASS_EN
        fwd       = 1'b0;
`endif
        for (int i = 0; i < NUM_READ; i++) begin
            ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
            rd_busy_c[i] = busy_q[ra];
`ifdef REG_FILE_BYPASS_EN
            fwd = 1'b0;
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                    rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                    fwd = 1'b1;
                end
            end
            if (fwd)
                rd_busy_c[i] = bus.rsv_en && (bus.rsv_addr == ra);
`endif
            if (ra == '0) begin
                rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy_c[i] = 1'b0;
            end
        end
    end

    always_comb begin : debug_view
        regs_flat = '0;
        for (int r = 0; r < NUM_REGS; r++)
            regs_flat[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
    end

    assign bus.rd_data       = rd_data_c;
    assign bus.rd_busy       = rd_busy_c;
    assign bus.busy_out      = busy_q;
    assign bus.registers_out = regs_flat;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp with two read and two write ports; directed scenarios then random traffic
// checked against a per-register reference model.
module tb_reg_file_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int NREGS = 32;
    localparam logic [DW-1:0] SP = 32'h03FF_FFFC;

    logic clock = 1'b0;
    logic reset = 1'b1;

    reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) bus ();

    reg_file_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW),
        .SP_INDEX(2), .INITIAL_SP(SP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_regs [NREGS];
    logic          m_busy [NREGS];

    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = (r == 2) ? SP : '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    function automatic bit write_hits(int r);
        for (int j = 0; j < NW; j++)
            if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == r) return 1'b1;
        return 1'b0;
    endfunction

    // Value the winning (last matching) write port carries for register r.
    function automatic logic [DW-1:0] write_value(int r);
        logic [DW-1:0] v = '0;
        for (int j = 0; j < NW; j++)
            if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == r) v = bus.wr_data[j*DW +: DW];
        return v;
    endfunction

    function automatic void model_edge();
        logic [DW-1:0] nv [NREGS];
        logic          nb [NREGS];
        for (int r = 1; r < NREGS; r++) begin
            nv[r] = write_hits(r) ? write_value(r) : m_regs[r];
            if (bus.flush)                                  nb[r] = 1'b0;
            else if (bus.rsv_en && int'(bus.rsv_addr) == r) nb[r] = 1'b1;
            else if (write_hits(r))                         nb[r] = 1'b0;
            else                                            nb[r] = m_busy[r];
        end
        for (int r = 1; r < NREGS; r++) begin
            m_regs[r] = nv[r];
            m_busy[r] = nb[r];
        end
    endfunction

    function automatic logic [DW-1:0] exp_data(int a);
        if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (write_hits(a)) return write_value(a);
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(int a);
        if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
        if (write_hits(a)) return bus.rsv_en && int'(bus.rsv_addr) == a;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [NREGS-1:0] model_busy_vec();
        logic [NREGS-1:0] v = '0;
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic drive_idle();
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic set_rd(int i, logic [AW-1:0] a);
        bus.rd_addr[i*AW +: AW] = a;
    endtask

    task automatic set_wr(int j, logic en, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.wr_en[j]            = en;
        bus.wr_addr[j*AW +: AW] = a;
        bus.wr_data[j*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        set_rd(0, 5'd2);
        set_rd(1, 5'd0);
        #1;
        total++;
        if (bus.rd_data[0 +: DW] !== SP) begin
            bad++; $display("FAIL reset_sp: got %h want %h", bus.rd_data[0 +: DW], SP);
        end
        total++;
        if (bus.rd_data[DW +: DW] !== 32'h0) begin
            bad++; $display("FAIL reset_x0: got %h want 0", bus.rd_data[DW +: DW]);
        end
        total++;
        if (bus.busy_out !== 32'h0) begin
            bad++; $display("FAIL reset_busy: got %h want 0", bus.busy_out);
        end
        for (int r = 0; r < NREGS; r++) begin
            total++;
            if (bus.registers_out[r*DW +: DW] !== ((r == 2) ? SP : 32'h0)) begin
                bad++; $display("FAIL reset_reg%0d: got %h", r, bus.registers_out[r*DW +: DW]);
            end
        end
    endtask

    task automatic test_write_read();
        drive_idle();
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive_idle();
        set_rd(0, 5'd5);
        #1;
        total++;
        if (bus.rd_data[0 +: DW] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL write_x5: got %h want deadbeef", bus.rd_data[0 +: DW]);
        end
        set_wr(1, 1'b1, 5'd0, 32'h1234);
        tick();
        drive_idle();
        set_rd(1, 5'd0);
        #1;
        total++;
        if (bus.rd_data[DW +: DW] !== 32'h0 || bus.registers_out[0 +: DW] !== 32'h0) begin
            bad++; $display("FAIL write_x0: got %h want 0", bus.rd_data[DW +: DW]);
        end
    endtask

    task automatic test_write_conflict();
        drive_idle();
        set_wr(0, 1'b1, 5'd7, 32'h1);
        set_wr(1, 1'b1, 5'd7, 32'h2);
        tick();
        drive_idle();
        set_rd(0, 5'd7);
        #1;
        total++;
        if (bus.rd_data[0 +: DW] !== 32'h2) begin
            bad++; $display("FAIL conflict_x7: got %h want 2", bus.rd_data[0 +: DW]);
        end
    endtask

    task automatic test_reserve();
        drive_idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
        tick();
        drive_idle();
        set_rd(1, 5'd9);
        #1;
        total++;
        if (bus.busy_out[9] !== 1'b1 || bus.rd_busy[1] !== 1'b1) begin
            bad++; $display("FAIL rsv_x9: got busy=%b rd_busy=%b want 1/1", bus.busy_out[9], bus.rd_busy[1]);
        end
        set_wr(0, 1'b1, 5'd9, 32'h99);
        tick();
        drive_idle();
        set_rd(1, 5'd9);
        #1;
        total++;
        if (bus.busy_out[9] !== 1'b0 || bus.rd_busy[1] !== 1'b0 || bus.rd_data[DW +: DW] !== 32'h99) begin
            bad++; $display("FAIL wb_x9: got busy=%b data=%h want 0/99", bus.busy_out[9], bus.rd_data[DW +: DW]);
        end
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
        set_wr(1, 1'b1, 5'd9, 32'h1234_5678);
        tick();
        drive_idle();
        set_rd(0, 5'd9);
        #1;
        total++;
        if (bus.busy_out[9] !== 1'b1 || bus.rd_data[0 +: DW] !== 32'h1234_5678) begin
            bad++; $display("FAIL rsv_wr_x9: got busy=%b data=%h want 1/12345678", bus.busy_out[9], bus.rd_data[0 +: DW]);
        end
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
        tick();
        drive_idle();
        #1;
        total++;
        if (bus.busy_out[0] !== 1'b0) begin
            bad++; $display("FAIL rsv_x0: got %b want 0", bus.busy_out[0]);
        end
    endtask

    task automatic test_flush();
        drive_idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        tick();
        bus.rsv_addr = 5'd4;
        tick();
        drive_idle();
        #1;
        total++;
        if (bus.busy_out !== 32'h0000_0218) begin
            bad++; $display("FAIL rsv_x3_x4: got %h want 00000218", bus.busy_out);
        end
        bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd6;
        tick();
        drive_idle();
        set_rd(0, 5'd6);
        #1;
        total++;
        if (bus.busy_out !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
            bad++; $display("FAIL flush: got busy=%h rd_busy=%b want 0/0", bus.busy_out, bus.rd_busy[0]);
        end
    endtask

    task automatic test_bypass();
        drive_idle();
        set_wr(0, 1'b1, 5'd10, 32'hA5A5_A5A5);
        set_rd(0, 5'd10);
        set_rd(1, 5'd0);
        #1;
        total++;
`ifdef REG_FILE_BYPASS_EN
        if (bus.rd_data[0 +: DW] !== 32'hA5A5_A5A5 || bus.rd_busy[0] !== 1'b0) begin
            bad++; $display("FAIL bypass_x10: got %h/%b want a5a5a5a5/0", bus.rd_data[0 +: DW], bus.rd_busy[0]);
        end
`else
        if (bus.rd_data[0 +: DW] !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
            bad++; $display("FAIL nobypass_x10: got %h/%b want 0/0", bus.rd_data[0 +: DW], bus.rd_busy[0]);
        end
`endif
        tick();
        drive_idle();
        set_rd(0, 5'd10);
        #1;
        total++;
        if (bus.rd_data[0 +: DW] !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL after_x10: got %h want a5a5a5a5", bus.rd_data[0 +: DW]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            for (int j = 0; j < NW; j++)
                set_wr(j, 1'($urandom_range(0, 1)),
                       AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                       $urandom);
            bus.rsv_en   = ($urandom_range(0, 2) == 0);
            bus.rsv_addr = AW'($urandom_range(0, 7));
            bus.flush    = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NR; i++) set_rd(i, AW'($urandom_range(0, 7)));
            #1;
            for (int i = 0; i < NR; i++) begin
                a = bus.rd_addr[i*AW +: AW];
                total++;
                if (bus.rd_data[i*DW +: DW] !== exp_data(int'(a))) begin
                    bad++; $display("FAIL rnd_rd%0d c%0d x%0d: got %h want %h", i, c, a, bus.rd_data[i*DW +: DW], exp_data(int'(a)));
                end
                total++;
                if (bus.rd_busy[i] !== exp_busy(int'(a))) begin
                    bad++; $display("FAIL rnd_busy%0d c%0d x%0d: got %b want %b", i, c, a, bus.rd_busy[i], exp_busy(int'(a)));
                end
            end
            tick();
            total++;
            if (bus.busy_out !== model_busy_vec()) begin
                bad++; $display("FAIL rnd_busyvec c%0d: got %h want %h", c, bus.busy_out, model_busy_vec());
            end
            for (int r = 0; r < NREGS; r++) begin
                total++;
                if (bus.registers_out[r*DW +: DW] !== m_regs[r]) begin
                    bad++; $display("FAIL rnd_reg%0d c%0d: got %h want %h", r, c, bus.registers_out[r*DW +: DW], m_regs[r]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        drive_idle();
        set_wr(0, 1'b1, 5'd12, 32'hCAFE_F00D);
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd13;
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.registers_out[2*DW +: DW] !== SP || bus.registers_out[5*DW +: DW] !== 32'h0 || bus.busy_out !== 32'h0) begin
            bad++; $display("FAIL async_reset: got sp=%h x5=%h busy=%h", bus.registers_out[2*DW +: DW], bus.registers_out[5*DW +: DW], bus.busy_out);
        end
        @(posedge clock);
        #1;
        total++;
        if (bus.registers_out[12*DW +: DW] !== 32'h0 || bus.busy_out !== 32'h0) begin
            bad++; $display("FAIL reset_override: got x12=%h busy=%h want 0/0", bus.registers_out[12*DW +: DW], bus.busy_out);
        end
        drive_idle();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_write_read();
        test_write_conflict();
        test_reserve();
        test_flush();
        test_bypass();
        test_random();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
